banner_sequencer: RTL and testbench

//  Sequences the on-screen text banners (FIGHT!, VICTORY!, DEFEAT!) over one round.

---
 rtl/banner_sequencer.sv | 148 ++++++++++++++
 tb/tb_banner_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/banner_sequencer.sv
// Round banner sequencer: FIGHT! -> play -> VICTORY!/DEFEAT! with blink, gating the
// word generators and muxing the selected glyph index/hit flag toward the font path.
module banner_sequencer #(
  parameter int unsigned FIGHT_FRAMES = 120,
  parameter int unsigned RESULT_MIN   = 60,
  parameter int unsigned BLINK_ON     = 20,
  parameter int unsigned BLINK_OFF    = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       VGA_VS,
  input  logic       round_start,
  input  logic       p1_dead,
  input  logic       p2_dead,
  input  logic       cont,
  input  logic [9:0] fight_n,
  input  logic       fight_is_word,
  input  logic [9:0] vict_n,
  input  logic       vict_is_word,
  input  logic [9:0] defeat_n,
  input  logic       defeat_is_word,
  output logic       fight_active,
  output logic       vict_active,
  output logic       defeat_active,
  output logic       frozen,
  output logic [9:0] word_n,
  output logic       is_word,
  output logic       round_done
);

  typedef enum logic [1:0] {IDLE, FIGHT, PLAY, RESULT} state_e;

  localparam logic [9:0] FIGHT_LAST = 10'(FIGHT_FRAMES - 1);
  localparam logic [9:0] RESULT_END = 10'(RESULT_MIN);
  localparam logic [9:0] BLINK_LAST = 10'(BLINK_ON + BLINK_OFF - 1);
  localparam logic [9:0] BLINK_VIS  = 10'(BLINK_ON);

  state_e     state_q, state_d;
  logic [9:0] frame_q, frame_d;
  logic [9:0] blink_q, blink_d;
  logic       win_q, win_d;
  logic       done_d;
  logic       vs_q;
  logic       tick;

  logic       fight_active_q, vict_active_q, defeat_active_q;
  logic       frozen_q, round_done_q, is_word_q;
  logic [9:0] word_n_q;

  assign tick = !vs_q && VGA_VS;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    blink_d = blink_q;
    win_d   = win_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (round_start) begin
          state_d = FIGHT;
          frame_d = '0;
        end
      end
      FIGHT: begin
        if (tick) begin
          frame_d = frame_q + 10'd1;
          if (frame_q == FIGHT_LAST) state_d = PLAY;
        end
      end
      PLAY: begin
        // Player 1 dying takes precedence, so a double KO is a defeat.
        if (p1_dead || p2_dead) begin
          state_d = RESULT;
          win_d   = !p1_dead;
          frame_d = '0;
          blink_d = '0;
        end
      end
      RESULT: begin
        if (tick) begin
          blink_d = (blink_q == BLINK_LAST) ? 10'd0 : blink_q + 10'd1;
          if (frame_q != RESULT_END) frame_d = frame_q + 10'd1;
        end
        if (cont && frame_q == RESULT_END) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= IDLE;
      frame_q         <= '0;
      blink_q         <= '0;
      win_q           <= 1'b0;
      vs_q            <= 1'b1;
      fight_active_q  <= 1'b0;
      vict_active_q   <= 1'b0;
      defeat_active_q <= 1'b0;
      frozen_q        <= 1'b1;
      round_done_q    <= 1'b0;
      word_n_q        <= '0;
      is_word_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_q         <= frame_d;
      blink_q         <= blink_d;
      win_q           <= win_d;
      vs_q            <= VGA_VS;
      fight_active_q  <= (state_d == FIGHT);
      vict_active_q   <= (state_d == RESULT) && win_d && (blink_d < BLINK_VIS);
      defeat_active_q <= (state_d == RESULT) && !win_d && (blink_d < BLINK_VIS);
      frozen_q        <= (state_d != PLAY);
      round_done_q    <= done_d;
      // Mux follows the enables already presented to the generators.
      if (fight_active_q) begin
        word_n_q  <= fight_n;
        is_word_q <= fight_is_word;
      end else if (vict_active_q) begin
        word_n_q  <= vict_n;
        is_word_q <= vict_is_word;
      end else if (defeat_active_q) begin
        word_n_q  <= defeat_n;
        is_word_q <= defeat_is_word;
      end else begin
        word_n_q  <= '0;
        is_word_q <= 1'b0;
      end
    end
  end

  assign fight_active  = fight_active_q;
  assign vict_active   = vict_active_q;
  assign defeat_active = defeat_active_q;
  assign frozen        = frozen_q;
  assign round_done    = round_done_q;
  assign word_n        = word_n_q;
  assign is_word       = is_word_q;

endmodule

// File: tb/tb_banner_sequencer.sv
// Directed bench for banner_sequencer: round flow, blink timing, continue gating,
// reset recovery and glyph mux, with expected values queued as stimulus is driven.
module tb_banner_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       VGA_VS;
  logic       round_start, p1_dead, p2_dead, cont;
  logic [9:0] fight_n, vict_n, defeat_n;
  logic       fight_is_word, vict_is_word, defeat_is_word;
  logic       fight_active, vict_active, defeat_active;
  logic       frozen, is_word, round_done;
  logic [9:0] word_n;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt;

  always #5 Clk = ~Clk;

  banner_sequencer dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .VGA_VS        (VGA_VS),
    .round_start   (round_start),
    .p1_dead       (p1_dead),
    .p2_dead       (p2_dead),
    .cont          (cont),
    .fight_n       (fight_n),
    .fight_is_word (fight_is_word),
    .vict_n        (vict_n),
    .vict_is_word  (vict_is_word),
    .defeat_n      (defeat_n),
    .defeat_is_word(defeat_is_word),
    .fight_active  (fight_active),
    .vict_active   (vict_active),
    .defeat_active (defeat_active),
    .frozen        (frozen),
    .word_n        (word_n),
    .is_word       (is_word),
    .round_done    (round_done)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One video frame: VS rises (one tick), then falls.
  task automatic frame();
    VGA_VS = 1'b1;
    tick();
    VGA_VS = 1'b0;
    tick();
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL sb_underflow: observed %0h with no expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    push(tag, exp);
    pop_check(obs);
  endtask

  task automatic pulse_round_start();
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
  endtask

  // Counts frames during which FIGHT! is enabled; bounded so a stuck FSM still ends.
  task automatic run_fight(output int frames);
    frames = 0;
    for (int i = 0; i < 200 && fight_active === 1'b1; i++) begin
      frames++;
      frame();
    end
  endtask

  task automatic check_idle(input string tag);
    expect_now({tag, "_fight"},  32'(fight_active),  32'd0);
    expect_now({tag, "_vict"},   32'(vict_active),   32'd0);
    expect_now({tag, "_defeat"}, 32'(defeat_active), 32'd0);
    expect_now({tag, "_frozen"}, 32'(frozen),        32'd1);
    expect_now({tag, "_done"},   32'(round_done),    32'd0);
  endtask

  initial begin
    Reset = 1'b1; VGA_VS = 1'b0;
    round_start = 1'b0; p1_dead = 1'b0; p2_dead = 1'b0; cont = 1'b0;
    fight_n  = 10'h3ff; fight_is_word  = 1'b1;
    vict_n   = 10'h01f; vict_is_word   = 1'b1;
    defeat_n = 10'h155; defeat_is_word = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check_idle("reset");
    expect_now("reset_word_n",  32'(word_n),  32'd0);
    expect_now("reset_is_word", 32'(is_word), 32'd0);

    // Victory round.
    pulse_round_start();
    expect_now("fight_enter", 32'(fight_active), 32'd1);
    expect_now("fight_frozen", 32'(frozen), 32'd1);
    tick();
    expect_now("fight_word_n", 32'(word_n), 32'h3ff);
    expect_now("fight_is_word", 32'(is_word), 32'd1);
    run_fight(cnt);
    expect_now("fight_frames", 32'(cnt), 32'd120);
    expect_now("play_fight", 32'(fight_active), 32'd0);
    expect_now("play_frozen", 32'(frozen), 32'd0);
    expect_now("play_word_n", 32'(word_n), 32'd0);

    p2_dead = 1'b1;
    tick();
    p2_dead = 1'b0;
    expect_now("vict_enter", 32'(vict_active), 32'd1);
    expect_now("vict_defeat_off", 32'(defeat_active), 32'd0);
    expect_now("vict_frozen", 32'(frozen), 32'd1);
    for (int j = 1; j <= 60; j++) begin
      frame();
      push("blink_vict", 32'((j % 30) < 20));
      push("blink_word_n", ((j % 30) < 20) ? 32'h1f : 32'h0);
      push("blink_is_word", 32'((j % 30) < 20));
      push("blink_defeat", 32'd0);
      push("blink_frozen", 32'd1);
      pop_check(32'(vict_active));
      pop_check(32'(word_n));
      pop_check(32'(is_word));
      pop_check(32'(defeat_active));
      pop_check(32'(frozen));
      if (j == 30) begin
        cont = 1'b1;
        tick();
        cont = 1'b0;
        expect_now("early_cont_done", 32'(round_done), 32'd0);
        expect_now("early_cont_stay", 32'(vict_active), 32'd1);
      end
    end
    cont = 1'b1;
    tick();
    cont = 1'b0;
    expect_now("cont_done", 32'(round_done), 32'd1);
    expect_now("cont_vict_off", 32'(vict_active), 32'd0);
    expect_now("cont_frozen", 32'(frozen), 32'd1);
    tick();
    expect_now("done_pulse_end", 32'(round_done), 32'd0);
    expect_now("idle_word_n", 32'(word_n), 32'd0);
    expect_now("idle_is_word", 32'(is_word), 32'd0);

    // Double KO resolves to defeat.
    pulse_round_start();
    run_fight(cnt);
    expect_now("fight2_frames", 32'(cnt), 32'd120);
    p1_dead = 1'b1;
    p2_dead = 1'b1;
    tick();
    p1_dead = 1'b0;
    p2_dead = 1'b0;
    expect_now("dko_defeat", 32'(defeat_active), 32'd1);
    expect_now("dko_vict", 32'(vict_active), 32'd0);
    tick();
    expect_now("dko_word_n", 32'(word_n), 32'h155);
    expect_now("dko_is_word", 32'(is_word), 32'd1);

    // Reset mid-RESULT, with round_start held to show it is overridden.
    frame();
    frame();
    Reset = 1'b1;
    round_start = 1'b1;
    tick();
    Reset = 1'b0;
    round_start = 1'b0;
    check_idle("rst_result");
    expect_now("rst_result_word", 32'(word_n), 32'd0);

    // Reset mid-FIGHT, then a fresh round must last the full 120 frames.
    pulse_round_start();
    for (int i = 0; i < 5; i++) frame();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_idle("rst_fight");
    pulse_round_start();
    run_fight(cnt);
    expect_now("fight3_frames", 32'(cnt), 32'd120);
    expect_now("fight3_frozen", 32'(frozen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
